// File: rtl/sound_fx_scheduler.sv
// Fixed-priority sound-effect scheduler: latches requests, plays one tone code for a timed duration, then a silent gap.
// Optional build macro SOUND_FX_PREEMPT_EN lets a lower-index request abort the effect in progress.
module sound_fx_scheduler #(
    parameter int N_REQ     = 4,
    parameter int DUR_W     = 10,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 20
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic [N_REQ-1:0]         req,
    input  logic [4*N_REQ-1:0]       code_in,
    input  logic [DUR_W*N_REQ-1:0]   dur_in,
    output logic [3:0]               sound_select,
    output logic [N_REQ-1:0]         grant,
    output logic                     done,
    output logic                     busy,
    output logic [N_REQ-1:0]         pending
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] GAP_LEN  = DUR_W'(GAP_TICKS);

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [3:0]         sound_q, sound_d;
    logic               done_q, done_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DUR_W-1:0]   tick_q, tick_d;
    logic [DUR_W-1:0]   dur_q, dur_d;

    logic               any_pending;
    logic [IDX_W-1:0]   winner;
    logic [3:0]         win_code;
    logic [DUR_W-1:0]   win_dur;
    logic               preempt;
    logic               start;
    logic               tick_wrap;
    logic [DUR_W-1:0]   tick_inc;
    logic [DUR_W-1:0]   limit;

    // Scan from the top so the lowest pending index is the last (and winning) assignment.
    always_comb begin
        any_pending = 1'b0;
        winner      = '0;
        win_code    = '0;
        win_dur     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                any_pending = 1'b1;
                winner      = IDX_W'(i);
                win_code    = code_in[4*i +: 4];
                win_dur     = dur_in[DUR_W*i +: DUR_W];
            end
        end
    end

`ifdef SOUND_FX_PREEMPT_EN
    logic [IDX_W-1:0] owner_q, owner_d;

    assign preempt = any_pending && (winner < owner_q);
    assign owner_d = (|grant_d) ? winner : owner_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) owner_q <= '0;
        else         owner_q <= owner_d;
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_d   = state_q;
        sound_d   = sound_q;
        grant_d   = '0;
        done_d    = 1'b0;
        pre_d     = pre_q;
        tick_d    = tick_q;
        dur_d     = dur_q;
        start     = 1'b0;
        tick_wrap = (pre_q == PRE_LAST);
        tick_inc  = tick_q + 1'b1;
        limit     = (state_q == ST_PLAY) ? dur_q : GAP_LEN;

        unique case (state_q)
            ST_IDLE: start = any_pending;
            ST_PLAY, ST_GAP: begin
                if (preempt) begin
                    start = 1'b1;
                end else if (tick_wrap) begin
                    pre_d  = '0;
                    tick_d = tick_inc;
                    if (tick_inc == limit) begin
                        tick_d = '0;
                        if (state_q == ST_PLAY) begin
                            sound_d = 4'd0;
                            done_d  = 1'b1;
                            state_d = (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A zero duration still plays for one tick.
        if (start) begin
            grant_d[winner] = 1'b1;
            sound_d         = win_code;
            dur_d           = (win_dur == '0) ? DUR_W'(1) : win_dur;
            pre_d           = '0;
            tick_d          = '0;
            state_d         = ST_PLAY;
        end

        pending_d = (pending_q & ~grant_d) | req;
    end

    // NOTE: flops update with non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            sound_q   <= 4'd0;
            done_q    <= 1'b0;
            pre_q     <= '0;
            tick_q    <= '0;
            dur_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            sound_q   <= sound_d;
            done_q    <= done_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            dur_q     <= dur_d;
        end
    end

    assign sound_select = sound_q;
    assign grant        = grant_q;
    assign done         = done_q;
    assign busy         = (state_q != ST_IDLE);
    assign pending      = pending_q;

endmodule

// File: tb/tb_sound_fx_scheduler.sv
// Self-checking bench for sound_fx_scheduler: directed scenarios plus randomized traffic against a
// cycle-count reference model (effect lengths computed as plain products of ticks and TICK_DIV).
`timescale 1ns/1ps
module tb_sound_fx_scheduler;
    localparam int N_REQ     = 4;
    localparam int DUR_W     = 10;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] code_in = '0;
    logic [39:0] dur_in = '0;
    logic [3:0]  sound_select;
    logic [3:0]  grant;
    logic        done;
    logic        busy;
    logic [3:0]  pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sound_fx_scheduler #(
        .N_REQ(N_REQ), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .CLOCK_50(clk), .resetn(resetn), .req(req), .code_in(code_in), .dur_in(dur_in),
        .sound_select(sound_select), .grant(grant), .done(done), .busy(busy), .pending(pending)
    );

    // Reference model: phase 0 idle, 1 play, 2 gap; m_left counts remaining clock cycles of the phase.
    int         m_phase = 0;
    int         m_left  = 0;
    int         m_owner = 0;
    logic [3:0] m_sound = '0;
    logic [3:0] m_grant = '0;
    logic [3:0] m_pend  = '0;
    logic       m_done  = 1'b0;

    always @(posedge clk or negedge resetn) begin : ref_model
        int win, d, p, left, own;
        bit start;
        logic [3:0] snd, g, pd;
        logic dn;
        if (!resetn) begin
            m_phase <= 0; m_left <= 0; m_owner <= 0;
            m_sound <= '0; m_grant <= '0; m_pend <= '0; m_done <= 1'b0;
        end else begin
            p = m_phase; left = m_left; own = m_owner; snd = m_sound; pd = m_pend;
            g = '0; dn = 1'b0; start = 0; win = -1;
            for (int i = 0; i < N_REQ; i++) if (pd[i] && win < 0) win = i;
            if (p == 0) begin
                start = (win >= 0);
            end else begin
`ifdef SOUND_FX_PREEMPT_EN
                if (win >= 0 && win < own) start = 1;
`endif
                if (!start) begin
                    left = left - 1;
                    if (left == 0) begin
                        if (p == 1) begin
                            dn = 1'b1; snd = 4'd0;
                            p = (GAP_TICKS > 0) ? 2 : 0;
                            left = GAP_TICKS * TICK_DIV;
                        end else begin
                            p = 0;
                        end
                    end
                end
            end
            if (start) begin
                g[win] = 1'b1;
                snd = code_in[4*win +: 4];
                d = int'(dur_in[DUR_W*win +: DUR_W]);
                left = ((d == 0) ? 1 : d) * TICK_DIV;
                p = 1;
                own = win;
            end
            pd = (pd & ~g) | req;
            m_phase <= p; m_left <= left; m_owner <= own;
            m_sound <= snd; m_grant <= g; m_pend <= pd; m_done <= dn;
        end
    end

    logic [13:0] dut_vec, exp_vec;
    assign dut_vec = {sound_select, grant, done, busy, pending};
    assign exp_vec = {m_sound, m_grant, m_done, (m_phase != 0), m_pend};

    task automatic set_src(input int i, input logic [3:0] c, input logic [9:0] d);
        code_in[4*i +: 4] = c;
        dur_in[10*i +: 10] = d;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        if (dut_vec !== 14'd0) begin
            errors++; $display("FAIL reset_hold got=%h exp=%h", dut_vec, 14'd0);
        end
        checks++;
        resetn = 1'b1;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            if (dut_vec !== 14'd0) begin
                errors++; $display("FAIL reset_idle s=%0d got=%h exp=%h", s, dut_vec, 14'd0);
            end
            checks++;
        end
    endtask

    task automatic test_single();
        int g_at = -1, n5 = 0, ndone = 0, nsil = 0;
        logic [3:0] g_val = '0;
        set_src(2, 4'd5, 10'd3);
        req = 4'b0100;
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL single_model s=%0d got=%h exp=%h", s, dut_vec, exp_vec);
            end
            checks++;
            req = '0;
            if (grant != 0 && g_at < 0) begin g_at = s; g_val = grant; end
            if (sound_select == 4'd5) n5++;
            if (done) ndone++;
            if (busy && sound_select == 4'd0) nsil++;
        end
        if (g_at !== 1 || g_val !== 4'b0100) begin
            errors++; $display("FAIL single_grant got=%0d/%b exp=1/0100", g_at, g_val);
        end
        checks++;
        if (n5 !== 12 || ndone !== 1 || nsil !== 8) begin
            errors++; $display("FAIL single_timing got play=%0d done=%0d gap=%0d exp 12/1/8", n5, ndone, nsil);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL single_idle got busy=%b exp 0", busy);
        end
        checks++;
    endtask

    task automatic test_priority();
        int g1 = -1, g3 = -1, idle_at = -1;
        logic p3_at_g1 = 1'b0;
        set_src(1, 4'd7, 10'd1);
        set_src(3, 4'd3, 10'd2);
        req = 4'b1010;
        for (int s = 0; s < 40; s++) begin
            @(negedge clk);
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL priority_model s=%0d got=%h exp=%h", s, dut_vec, exp_vec);
            end
            checks++;
            req = '0;
            if (grant == 4'b0010 && g1 < 0) begin g1 = s; p3_at_g1 = pending[3]; end
            if (grant == 4'b1000 && g3 < 0) g3 = s;
            if (g1 >= 0 && s > g1 && !busy && idle_at < 0) idle_at = s;
        end
        if (g1 !== 1 || g3 !== 14) begin
            errors++; $display("FAIL priority_order got g1=%0d g3=%0d exp g1=1 g3=14", g1, g3);
        end
        checks++;
        if (p3_at_g1 !== 1'b1) begin
            errors++; $display("FAIL priority_pending3 got=%b exp=1", p3_at_g1);
        end
        checks++;
        if (g3 !== idle_at + 1) begin
            errors++; $display("FAIL priority_gap_exit got g3=%0d exp=%0d", g3, idle_at + 1);
        end
        checks++;
    endtask

    task automatic test_merge();
        int n0 = 0, n2 = 0, exp_n0;
`ifdef SOUND_FX_PREEMPT_EN
        exp_n0 = 2;
`else
        exp_n0 = 1;
`endif
        set_src(2, 4'd4, 10'd3);
        set_src(0, 4'd6, 10'd1);
        req = 4'b0100;
        for (int s = 0; s < 45; s++) begin
            @(negedge clk);
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL merge_model s=%0d got=%h exp=%h", s, dut_vec, exp_vec);
            end
            checks++;
            req = (s == 3 || s == 6 || s == 9) ? 4'b0001 : 4'b0000;
            if (grant[0]) n0++;
            if (grant[2]) n2++;
        end
        if (n0 !== exp_n0 || n2 !== 1) begin
            errors++; $display("FAIL merge_count got g0=%0d g2=%0d exp g0=%0d g2=1", n0, n2, exp_n0);
        end
        checks++;
    endtask

    task automatic test_dur_zero();
        int n9 = 0, ndone = 0;
        set_src(1, 4'd9, 10'd0);
        req = 4'b0010;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL durzero_model s=%0d got=%h exp=%h", s, dut_vec, exp_vec);
            end
            checks++;
            req = '0;
            if (sound_select == 4'd9) n9++;
            if (done) ndone++;
        end
        if (n9 !== 4 || ndone !== 1) begin
            errors++; $display("FAIL durzero_len got play=%0d done=%0d exp 4/1", n9, ndone);
        end
        checks++;
    endtask

    task automatic test_preempt();
        int g0 = -1, done_before = 0, exp_g0, exp_done;
        logic [3:0] snd_at_g0 = '0;
`ifdef SOUND_FX_PREEMPT_EN
        exp_g0 = 5; exp_done = 0;
`else
        exp_g0 = 22; exp_done = 1;
`endif
        set_src(2, 4'd5, 10'd3);
        set_src(0, 4'hA, 10'd2);
        req = 4'b0100;
        for (int s = 0; s < 45; s++) begin
            @(negedge clk);
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL preempt_model s=%0d got=%h exp=%h", s, dut_vec, exp_vec);
            end
            checks++;
            req = (s == 3) ? 4'b0001 : 4'b0000;
            if (grant[0] && g0 < 0) begin g0 = s; snd_at_g0 = sound_select; end
            if (done && g0 < 0) done_before++;
        end
        if (g0 !== exp_g0 || snd_at_g0 !== 4'hA) begin
            errors++; $display("FAIL preempt_grant got at=%0d code=%h exp at=%0d code=a", g0, snd_at_g0, exp_g0);
        end
        checks++;
        if (done_before !== exp_done) begin
            errors++; $display("FAIL preempt_done got=%0d exp=%0d", done_before, exp_done);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int s = 0; s < 2000; s++) begin
            @(negedge clk);
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL random_model s=%0d got=%h exp=%h", s, dut_vec, exp_vec);
            end
            checks++;
            if (s == 1000) begin
                resetn = 1'b0;
                #1;
                if (dut_vec !== 14'd0 || exp_vec !== 14'd0) begin
                    errors++; $display("FAIL random_async_reset got=%h exp=%h", dut_vec, 14'd0);
                end
                checks++;
            end else if (s == 1002) begin
                resetn = 1'b1;
            end
            req = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            code_in = 16'($urandom);
            for (int i = 0; i < N_REQ; i++) dur_in[10*i +: 10] = 10'($urandom_range(0, 3));
        end
        req = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_merge();
        test_dur_zero();
        test_preempt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
